current_fir_filter_mc: RTL and testbench

Multi-channel, parametrised successor to the fixed 7-tap current-sense FIR low-pass. One time-multiplexed multiply-accumulate filters CHANNELS interleaved current samples per Avalon-ST beat with a TAPS-deep direct-form FIR. Coefficients are run-time loadable through a small write port. The block sits between the current ADC deserialiser and the motor current controllers.

---
 rtl/current_fir_filter_mc.sv | 258 +++++++++++++++++++++++++
 tb/tb_current_fir_filter_mc.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/current_fir_filter_mc.sv
// -----------------------------------------------------------------------------
// current_fir_filter_mc
//
// Multi-channel direct-form FIR low-pass for interleaved current samples.
// A single time-multiplexed multiply-accumulate filters CHANNELS samples per
// Avalon-ST beat with a TAPS-deep filter. The coefficients are loadable at run
// time through a small write port.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_data/valid/ready   Avalon-ST sink, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_data/valid/ready  Avalon-ST source, same packing as in_data
//   out_clip          per-channel saturation flag for the current out_data
//   coef_address/writedata/write/waitrequest  coefficient write port;
//                     h[k] multiplies x[n-k]
//
// Build option:
//   CURRENT_FIR_SATURATE_EN  when defined, results clamp to the DATA_WIDTH range
//                            and out_clip reports it. When undefined, results
//                            wrap and out_clip is tied to 0.
//
// Sequencing: CLEAR (zero the history) -> IDLE -> MAC (CHANNELS*TAPS products,
// channel-major) -> DRAIN (2 cycles of pipeline flush) -> IDLE.
// -----------------------------------------------------------------------------
module current_fir_filter_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int TAPS       = 8,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS-1:0]            out_clip,
  input  logic [$clog2(TAPS)-1:0]        coef_address,
  input  logic [COEF_WIDTH-1:0]          coef_writedata,
  input  logic                           coef_write,
  output logic                           coef_waitrequest
);

  localparam int AW  = $clog2(TAPS);
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW  = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC = PW + $clog2(TAPS);

  // Half an LSB of the output, so the final arithmetic shift rounds half-up.
  localparam logic signed [ACC-1:0] ROUND = ACC'(1) << (COEF_FRAC - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_MAC,
    S_DRAIN
  } state_e;

  // Control state
  state_e          state_q;
  logic [AW-1:0]   tap_q;
  logic [CW-1:0]   ch_q;
  logic            drain_q;
  logic            out_valid_q;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data_q;

  // Datapath storage
  logic [CHANNELS*DATA_WIDTH-1:0]  x_q;
  logic signed [DATA_WIDTH-1:0]    hist_q     [CHANNELS][TAPS-1];
  logic signed [COEF_WIDTH-1:0]    coef_q     [TAPS];
  logic signed [COEF_WIDTH-1:0]    coef_act_q [TAPS];
  logic signed [DATA_WIDTH-1:0]    res_q      [CHANNELS];

  // Product stage -> accumulate stage
  logic                 p_valid_q;
  logic                 p_first_q;
  logic                 p_last_q;
  logic [CW-1:0]        p_ch_q;
  logic signed [PW-1:0] prod_q;
  logic signed [ACC-1:0] acc_q;

  logic                          accept;
  logic                          coef_addr_ok;
  logic signed [DATA_WIDTH-1:0]  x_arr [CHANNELS];
  logic signed [DATA_WIDTH-1:0]  mac_x;
  logic signed [PW-1:0]          mac_prod;
  logic signed [ACC-1:0]         acc_d;
  logic signed [DATA_WIDTH-1:0]  res_d;

  assign in_ready         = (state_q == S_IDLE) && !out_valid_q;
  assign accept           = in_valid && in_ready;
  assign coef_waitrequest = (state_q == S_MAC) || (state_q == S_DRAIN);
  assign coef_addr_ok     = {1'b0, coef_address} < (AW+1)'(TAPS);
  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;

  // Operand select: tap 0 is the freshly latched sample, tap k>0 is history k-1.
  // NOTE: every always_comb output gets a value before any conditional
  // override, so no path can leave it unassigned and infer a latch.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      x_arr[c] = x_q[c*DATA_WIDTH +: DATA_WIDTH];
    end
    mac_x = x_arr[ch_q];
    if (tap_q != '0) begin
      mac_x = hist_q[ch_q][tap_q - AW'(1)];
    end
    mac_prod = PW'(mac_x) * PW'(coef_act_q[tap_q]);
  end

  // First tap of a channel restarts the sum from the rounding constant.
  assign acc_d = (p_first_q ? ROUND : acc_q) + ACC'(prod_q);

`ifdef CURRENT_FIR_SATURATE_EN
  logic                               clip_d;
  logic [ACC-COEF_FRAC-DATA_WIDTH:0]  res_hi;
  logic [CHANNELS-1:0]                res_clip_q;
  logic [CHANNELS-1:0]                out_clip_q;

  // The shifted result fits when all bits from its sign position upward agree.
  always_comb begin
    res_hi = acc_d[ACC-1:COEF_FRAC+DATA_WIDTH-1];
    res_d  = acc_d[COEF_FRAC +: DATA_WIDTH];
    clip_d = 1'b0;
    if (!((&res_hi) || !(|res_hi))) begin
      clip_d = 1'b1;
      res_d  = acc_d[ACC-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_clip_q <= '0;
      out_clip_q <= '0;
    end else begin
      if (p_valid_q && p_last_q) res_clip_q[p_ch_q] <= clip_d;
      if (state_q == S_DRAIN && drain_q) out_clip_q <= res_clip_q;
    end
  end

  assign out_clip = out_clip_q;
`else
  assign res_d    = acc_d[COEF_FRAC +: DATA_WIDTH];
  assign out_clip = '0;
`endif

  // Control FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      tap_q       <= '0;
      ch_q        <= '0;
      drain_q     <= 1'b0;
      p_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      p_valid_q <= 1'b0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;

      case (state_q)
        S_CLEAR: begin
          if (tap_q == AW'(TAPS-2)) begin
            tap_q <= '0;
            if (ch_q == CW'(CHANNELS-1)) begin
              ch_q    <= '0;
              state_q <= S_IDLE;
            end else begin
              ch_q <= ch_q + CW'(1);
            end
          end else begin
            tap_q <= tap_q + AW'(1);
          end
        end
        S_IDLE: begin
          if (accept) state_q <= S_MAC;
        end
        S_MAC: begin
          p_valid_q <= 1'b1;
          if (tap_q == AW'(TAPS-1)) begin
            tap_q <= '0;
            if (ch_q == CW'(CHANNELS-1)) begin
              ch_q    <= '0;
              state_q <= S_DRAIN;
            end else begin
              ch_q <= ch_q + CW'(1);
            end
          end else begin
            tap_q <= tap_q + AW'(1);
          end
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            drain_q     <= 1'b0;
            out_valid_q <= 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
              out_data_q[c*DATA_WIDTH +: DATA_WIDTH] <= res_q[c];
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // Datapath pipeline: product register, then accumulate and reduce.
  always_ff @(posedge clk) begin
    if (accept) x_q <= in_data;
    prod_q    <= mac_prod;
    p_first_q <= (tap_q == '0);
    p_last_q  <= (tap_q == AW'(TAPS-1));
    p_ch_q    <= ch_q;
    if (p_valid_q) begin
      acc_q <= acc_d;
      if (p_last_q) res_q[p_ch_q] <= res_d;
    end
  end

  // History: zeroed word by word in CLEAR, shifted once per channel after
  // that channel's last tap has been read.
  // NOTE: storage arrays carry no reset; CLEAR zeroes the history and the
  // coefficients deliberately survive reset.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      hist_q[ch_q][tap_q] <= '0;
    end else if (state_q == S_MAC && tap_q == AW'(TAPS-1)) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_q == CW'(c)) begin
          for (int k = TAPS-2; k > 0; k--) begin
            hist_q[c][k] <= hist_q[c][k-1];
          end
          hist_q[c][0] <= x_arr[c];
        end
      end
    end
  end

  // Coefficients: writes land in coef_q; the active bank is snapshotted at
  // each accept, so a write in the same cycle as an accept applies from the
  // following sample. The array relies on the device's zero power-up state.
  always_ff @(posedge clk) begin
    if (coef_write && !coef_waitrequest && coef_addr_ok) begin
      coef_q[coef_address] <= coef_writedata;
    end
    if (accept) begin
      for (int k = 0; k < TAPS; k++) coef_act_q[k] <= coef_q[k];
    end
  end

endmodule

// File: tb/tb_current_fir_filter_mc.sv
// -----------------------------------------------------------------------------
// tb_current_fir_filter_mc
//
// Directed bench for current_fir_filter_mc with default parameters
// (16-bit data, 2 channels, 8 taps, Q1.15 coefficients). Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_current_fir_filter_mc;

  localparam int DW   = 16;
  localparam int CH   = 2;
  localparam int TAPS = 8;
  localparam int LAT  = CH*TAPS + 3;
  localparam int CLR  = CH*(TAPS-1);

  logic             clk = 1'b0;
  logic             reset;
  logic [CH*DW-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [CH*DW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CH-1:0]    out_clip;
  logic [2:0]       coef_address;
  logic [15:0]      coef_writedata;
  logic             coef_write;
  logic             coef_waitrequest;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  current_fir_filter_mc #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .TAPS(TAPS), .COEF_WIDTH(16), .COEF_FRAC(15)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_clip(out_clip),
    .coef_address(coef_address), .coef_writedata(coef_writedata),
    .coef_write(coef_write), .coef_waitrequest(coef_waitrequest)
  );

  int imp_h   [TAPS] = '{1000, 2000, 3000, 4000, 4000, 3000, 2000, 1000};
  int imp_exp [TAPS] = '{500, 1000, 1500, 2000, 2000, 1500, 1000, 500};

  // ---------------------------------------------------------------- helpers
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; coef_write = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic write_coef(input int addr, input int val);
    int n;
    @(negedge clk);
    coef_address = 3'(addr); coef_writedata = 16'(val); coef_write = 1'b1;
    n = 0;
    while (coef_waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    coef_write = 1'b0;
  endtask

  task automatic load_coefs(input int h [TAPS]);
    for (int k = 0; k < TAPS; k++) write_coef(k, h[k]);
  endtask

  // Presents one beat, waits for its result; lat counts cycles from accept.
  task automatic send_beat(input int x0, input int x1, output int y0, output int y1,
                           output logic [CH-1:0] clip, output int lat);
    int n;
    @(negedge clk);
    in_data = {16'(x1), 16'(x0)}; in_valid = 1'b1;
    wait_ready(n);
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    y0   = int'($signed(out_data[15:0]));
    y1   = int'($signed(out_data[31:16]));
    clip = out_clip;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < CLR; i++) begin
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
          out_clip !== '0 || coef_waitrequest !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold cyc %0d: in_ready=%b out_valid=%b out_data=%h clip=%b waitreq=%b, required all 0",
                 i, in_ready, out_valid, out_data, out_clip, coef_waitrequest);
      end
      @(negedge clk);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_impulse();
    int n, y0, y1, lat;
    logic [CH-1:0] clip;
    do_reset();
    wait_ready(n);
    load_coefs(imp_h);
    for (int i = 0; i < TAPS; i++) begin
      send_beat((i == 0) ? 16384 : 0, (i == 0) ? -16384 : 0, y0, y1, clip, lat);
      tests++;
      if (y0 !== imp_exp[i]) begin
        fails++; $display("FAIL impulse_ch0 beat %0d: got %0d, required %0d", i, y0, imp_exp[i]);
      end
      tests++;
      if (y1 !== -imp_exp[i]) begin
        fails++; $display("FAIL impulse_ch1 beat %0d: got %0d, required %0d", i, y1, -imp_exp[i]);
      end
      tests++;
      if (lat !== LAT) begin
        fails++; $display("FAIL impulse_latency beat %0d: got %0d, required %0d", i, lat, LAT);
      end
    end
  endtask

  task automatic test_rounding();
    int n, y0, y1, lat;
    logic [CH-1:0] clip;
    int h   [TAPS] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int xs  [6]    = '{16384, -16384, 16383, 16384, -16384, 16383};
    int exp [6]    = '{1, 0, 0, 1, 0, 0};
    do_reset();
    wait_ready(n);
    load_coefs(h);
    for (int b = 0; b < 3; b++) begin
      send_beat(xs[2*b], xs[2*b+1], y0, y1, clip, lat);
      tests++;
      if (y0 !== exp[2*b] || y1 !== exp[2*b+1]) begin
        fails++;
        $display("FAIL rounding beat %0d: got (%0d,%0d), required (%0d,%0d)",
                 b, y0, y1, exp[2*b], exp[2*b+1]);
      end
    end
  endtask

  task automatic test_saturation();
    int n, y0, y1, lat, ey;
    logic [CH-1:0] clip, eclip;
    longint raw;
    logic [15:0] w;
    int h [TAPS] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    do_reset();
    wait_ready(n);
    load_coefs(h);
    for (int j = 1; j <= TAPS; j++) begin
      raw = (longint'(j) * 32767 * 32767 + 16384) >>> 15;
`ifdef CURRENT_FIR_SATURATE_EN
      ey    = (raw > 32767) ? 32767 : int'(raw);
      eclip = (raw > 32767) ? 2'b11 : 2'b00;
`else
      w     = raw[15:0];
      ey    = int'($signed(w));
      eclip = 2'b00;
`endif
      send_beat(32767, 32767, y0, y1, clip, lat);
      tests++;
      if (y0 !== ey || y1 !== ey || clip !== eclip) begin
        fails++;
        $display("FAIL saturation beat %0d: got (%0d,%0d) clip=%b, required (%0d,%0d) clip=%b",
                 j, y0, y1, clip, ey, ey, eclip);
      end
    end
  endtask

  task automatic test_backpressure();
    int n, y0, y1, lat;
    logic [CH-1:0] clip;
    logic [CH*DW-1:0] held;
    do_reset();
    wait_ready(n);
    load_coefs(imp_h);
    out_ready = 1'b0;
    send_beat(16384, 0, y0, y1, clip, lat);
    tests++;
    if (y0 !== 500 || lat !== LAT) begin
      fails++; $display("FAIL bp_first: got y0=%0d lat=%0d, required 500 lat=%0d", y0, lat, LAT);
    end
    held = out_data;
    in_data = {16'(0), 16'(16384)}; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cyc %0d: out_valid=%b out_data=%h in_ready=%b, required 1 %h 0",
                 i, out_valid, out_data, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    y0 = int'($signed(out_data[15:0]));
    y1 = int'($signed(out_data[31:16]));
    tests++;
    if (y0 !== 1500 || y1 !== 0 || lat !== LAT) begin
      fails++;
      $display("FAIL bp_pending_beat: got (%0d,%0d) lat=%0d, required (1500,0) lat=%0d", y0, y1, lat, LAT);
    end
  endtask

  task automatic test_coef_during_mac();
    int n, y0, y1, lat;
    logic [CH-1:0] clip;
    do_reset();
    wait_ready(n);
    load_coefs(imp_h);
    @(negedge clk);
    in_data = {16'(-16384), 16'(16384)}; in_valid = 1'b1;
    wait_ready(n);
    @(negedge clk);
    in_valid = 1'b0;
    coef_address = 3'd0; coef_writedata = 16'd2000; coef_write = 1'b1;
    n = 0;
    while (coef_waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== LAT - 1) begin
      fails++; $display("FAIL mac_waitreq_cycles: got %0d, required %0d", n, LAT - 1);
    end
    y0 = int'($signed(out_data[15:0]));
    y1 = int'($signed(out_data[31:16]));
    tests++;
    if (out_valid !== 1'b1 || y0 !== 500 || y1 !== -500) begin
      fails++;
      $display("FAIL mac_old_coef: valid=%b got (%0d,%0d), required 1 (500,-500)", out_valid, y0, y1);
    end
    @(negedge clk);
    coef_write = 1'b0;
    send_beat(16384, -16384, y0, y1, clip, lat);
    tests++;
    if (y0 !== 2000 || y1 !== -2000) begin
      fails++; $display("FAIL mac_new_coef: got (%0d,%0d), required (2000,-2000)", y0, y1);
    end
  endtask

  task automatic test_write_with_accept();
    int n, y0, y1, lat;
    logic [CH-1:0] clip;
    do_reset();
    wait_ready(n);
    load_coefs(imp_h);
    @(negedge clk);
    in_data = {16'(0), 16'(16384)}; in_valid = 1'b1;
    coef_address = 3'd0; coef_writedata = 16'd3000; coef_write = 1'b1;
    tests++;
    if (in_ready !== 1'b1 || coef_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL sim_ready: in_ready=%b waitreq=%b, required 1 0", in_ready, coef_waitrequest);
    end
    @(negedge clk);
    in_valid = 1'b0; coef_write = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    y0 = int'($signed(out_data[15:0]));
    tests++;
    if (y0 !== 500) begin
      fails++; $display("FAIL sim_same_sample: got %0d, required 500", y0);
    end
    send_beat(16384, 0, y0, y1, clip, lat);
    tests++;
    if (y0 !== 2500) begin
      fails++; $display("FAIL sim_next_sample: got %0d, required 2500", y0);
    end
  endtask

  task automatic test_reset_mid_mac();
    int n, y0, y1, lat;
    logic [CH-1:0] clip;
    logic pulse;
    do_reset();
    wait_ready(n);
    load_coefs(imp_h);
    send_beat(16384, -16384, y0, y1, clip, lat);
    @(negedge clk);
    in_data = {16'(-16384), 16'(16384)}; in_valid = 1'b1;
    wait_ready(n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || coef_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL midmac_reset: out_valid=%b in_ready=%b waitreq=%b, required 0 0 0",
               out_valid, in_ready, coef_waitrequest);
    end
    reset = 1'b0;
    pulse = 1'b0;
    n = 0;
    while (!in_ready && n < 200) begin
      if (out_valid) pulse = 1'b1;
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== CLR || pulse !== 1'b0) begin
      fails++;
      $display("FAIL midmac_clear: clear cycles=%0d out_valid_seen=%b, required %0d 0", n, pulse, CLR);
    end
    send_beat(16384, -16384, y0, y1, clip, lat);
    tests++;
    if (y0 !== 500 || y1 !== -500) begin
      fails++; $display("FAIL midmac_impulse0: got (%0d,%0d), required (500,-500)", y0, y1);
    end
    send_beat(0, 0, y0, y1, clip, lat);
    tests++;
    if (y0 !== 1000 || y1 !== -1000) begin
      fails++; $display("FAIL midmac_impulse1: got (%0d,%0d), required (1000,-1000)", y0, y1);
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    coef_address = '0; coef_writedata = '0; coef_write = 1'b0;
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_coef_during_mac();
    test_write_with_accept();
    test_reset_mid_mac();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
